uart_rx_deframer: RTL and testbench

//  Serial receive front-end of the UART block. Oversamples rxd, deframes 9-bit-mode frames
//  (start, data LSB-first, type bit, optional even parity, stop) into one buffered transaction.
//  The type bit maps to trans_type_t: 0=UART_COMMAND, 1=UART_RESPONSE.

---
 rtl/uart_typedef_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_deframer.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_typedef_pkg.sv
// Shared UART types: transaction tag, receive FSM states and synchronizer depth.
package uart_typedef_pkg;

  typedef enum logic {
    UART_COMMAND  = 1'b0,
    UART_RESPONSE = 1'b1
  } trans_type_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    TYPE   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5,
    BREAK  = 3'd6
  } rx_state_t;

  localparam int UART_RX_SYNC_STAGES = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divides clk by max(baud_div,1), with a clear that parks the count at 0.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] baud_div,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_eff;
  logic        wrap;

  assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign wrap    = (cnt_q == div_eff - 16'd1);
  assign tick    = wrap && !clear;

  // Next count: held at 0 while cleared, otherwise wraps after div_eff cycles.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear || wrap) begin
      cnt_d = 16'd0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes rxd, oversamples 9-bit-mode frames and buffers one transaction.
module uart_rx_deframer
  import uart_typedef_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          baud_div,
  input  logic                 rxd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output trans_type_t          out_type,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 overrun
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_FULL = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic [UART_RX_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                           rxd_s;
  logic                           rxd_prev_q, rxd_prev_d;
  rx_state_t                      state_q, state_d;
  logic [OS_W-1:0]                os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]               bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]           shift_q, shift_d;
  logic                           type_q, type_d;
  logic                           perr_q, perr_d;
  logic                           out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0]           out_data_q, out_data_d;
  trans_type_t                    out_type_q, out_type_d;
  logic                           out_perr_q, out_perr_d;
  logic                           out_ferr_q, out_ferr_d;
  logic                           overrun_q, overrun_d;
  logic                           tick;
  logic                           sample;

  assign rxd_s  = sync_q[UART_RX_SYNC_STAGES-1];
  assign sync_d = {sync_q[UART_RX_SYNC_STAGES-2:0], rxd};
  assign sample = tick && (os_cnt_q == OS_FULL);

  uart_baud_tick u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // Frame FSM, shift register and output buffer next-state logic.
  always_comb begin
    rxd_prev_d  = rxd_s;
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    type_d      = type_q;
    perr_d      = perr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_type_d  = out_type_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    overrun_d   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (tick) begin
      os_cnt_d = (os_cnt_q == OS_FULL) ? '0 : os_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        os_cnt_d  = '0;
        bit_cnt_d = '0;
        if (rxd_prev_q && !rxd_s) begin
          state_d = START;
        end
      end
      START: begin
        if (tick && (os_cnt_q == OS_HALF)) begin
          os_cnt_d = '0;
          state_d  = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = TYPE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      TYPE: begin
        if (sample) begin
          type_d  = rxd_s;
          perr_d  = 1'b0;
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) begin
          perr_d  = ^{shift_q, type_q, rxd_s};
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_q;
            out_type_d  = trans_type_t'(type_q);
            out_perr_d  = (PARITY_EN != 0) ? perr_q : 1'b0;
            out_ferr_d  = !rxd_s;
          end else begin
            overrun_d = 1'b1;
          end
          state_d = rxd_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      rxd_prev_q  <= 1'b1;
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      type_q      <= 1'b0;
      perr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_type_q  <= UART_COMMAND;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rxd_prev_q  <= rxd_prev_d;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      type_q      <= type_d;
      perr_q      <= perr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_type_q  <= out_type_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_type       = out_type_q;
  assign out_parity_err = out_perr_q;
  assign out_frame_err  = out_ferr_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: table-driven frames plus hand-written corner sequences.
module tb_uart_rx_deframer;
  import uart_typedef_pkg::*;

  localparam int BIT_CLKS = 64;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic        rxd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  trans_type_t out_type;
  logic        out_parity_err;
  logic        out_frame_err;
  logic        overrun;

  typedef struct {
    logic [7:0] data;
    logic       typ;
    logic       bad_par;
    logic [7:0] exp_data;
    logic       exp_type;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       typ;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   assertions;
  int   failures;
  int   delivered;
  int   ovr_cnt;

  uart_rx_deframer #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .PARITY_EN  (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_div       (baud_div),
    .rxd            (rxd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_type       (out_type),
    .out_parity_err (out_parity_err),
    .out_frame_err  (out_frame_err),
    .overrun        (overrun)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and log a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n clocks, landing 1 ns after the rising edge.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold rxd at one level for n clocks.
  task automatic driveBit(input logic b, input int n);
    rxd = b;
    waitCycles(n);
  endtask

  // Serialize one frame: start, data LSB first, type, parity, stop.
  task automatic sendFrame(input logic [7:0] data, input logic typ, input logic par,
                           input logic stop, input int stop_clks);
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) driveBit(data[i], BIT_CLKS);
    driveBit(typ, BIT_CLKS);
    driveBit(par, BIT_CLKS);
    driveBit(stop, stop_clks);
  endtask

  // Push the expected transaction and send a well-stopped frame for one table entry.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    logic par;
    par    = (^{v.data, v.typ}) ^ v.bad_par;
    e.data = v.exp_data;
    e.typ  = v.exp_type;
    e.perr = v.exp_perr;
    e.ferr = 1'b0;
    sb.push_back(e);
    sendFrame(v.data, v.typ, par, 1'b1, BIT_CLKS);
    driveBit(1'b1, 40);
  endtask

  // Scoreboard monitor: every accepted transaction is compared against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        delivered++;
        if (sb.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpected_output: got data 0x%0h, expected no transaction", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(e.data));
          checkOutput("out_type", 32'(out_type), 32'(e.typ));
          checkOutput("out_parity_err", 32'(out_parity_err), 32'(e.perr));
          checkOutput("out_frame_err", 32'(out_frame_err), 32'(e.ferr));
        end
      end
    end
  end

  initial begin
    vec_t vecs[5];
    exp_t e;
    int   ovr_before;
    int   del_before;

    assertions = 0;
    failures   = 0;
    delivered  = 0;
    ovr_cnt    = 0;

    vecs[0] = '{data: 8'hA5, typ: 1'b1, bad_par: 1'b0, exp_data: 8'hA5, exp_type: 1'b1, exp_perr: 1'b0};
    vecs[1] = '{data: 8'h3C, typ: 1'b0, bad_par: 1'b1, exp_data: 8'h3C, exp_type: 1'b0, exp_perr: 1'b1};
    vecs[2] = '{data: 8'h00, typ: 1'b0, bad_par: 1'b0, exp_data: 8'h00, exp_type: 1'b0, exp_perr: 1'b0};
    vecs[3] = '{data: 8'hFF, typ: 1'b1, bad_par: 1'b0, exp_data: 8'hFF, exp_type: 1'b1, exp_perr: 1'b0};
    vecs[4] = '{data: 8'h81, typ: 1'b0, bad_par: 1'b1, exp_data: 8'h81, exp_type: 1'b0, exp_perr: 1'b1};

    rst       = 1'b1;
    rxd       = 1'b1;
    out_ready = 1'b1;
    baud_div  = 16'd4;
    waitCycles(5);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_type", 32'(out_type), 32'(UART_COMMAND));
    checkOutput("reset_errs", 32'({out_parity_err, out_frame_err}), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    waitCycles(10);

    $display("[TB] table-driven frames");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    $display("[TB] stop bit low followed by a long break");
    e = '{data: 8'h5A, typ: 1'b0, perr: 1'b0, ferr: 1'b1};
    sb.push_back(e);
    sendFrame(8'h5A, 1'b0, 1'b0, 1'b0, BIT_CLKS);
    driveBit(1'b0, 100);
    checkOutput("break_state", 32'(dut.state_q), 32'(BREAK));
    driveBit(1'b0, 100);
    checkOutput("break_no_valid", 32'(out_valid), 32'd0);
    driveBit(1'b1, 100);
    checkOutput("break_exit_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] short glitch on rxd");
    del_before = delivered;
    driveBit(1'b0, 20);
    driveBit(1'b1, 200);
    checkOutput("glitch_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("glitch_no_output", 32'(delivered), 32'(del_before));

    $display("[TB] overrun with consumer stalled");
    out_ready  = 1'b0;
    ovr_before = ovr_cnt;
    e = '{data: 8'h11, typ: 1'b0, perr: 1'b0, ferr: 1'b0};
    sb.push_back(e);
    sendFrame(8'h11, 1'b0, ^8'h11, 1'b1, BIT_CLKS);
    sendFrame(8'h22, 1'b0, ^8'h22, 1'b1, BIT_CLKS);
    driveBit(1'b1, 20);
    checkOutput("overrun_pulses", 32'(ovr_cnt - ovr_before), 32'd1);
    checkOutput("overrun_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("overrun_hold_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    waitCycles(3);
    checkOutput("overrun_valid_drop", 32'(out_valid), 32'd0);

    $display("[TB] reset in the middle of a frame");
    driveBit(1'b0, BIT_CLKS);
    driveBit(1'b1, BIT_CLKS);
    driveBit(1'b0, BIT_CLKS);
    driveBit(1'b1, 30);
    rxd = 1'b1;
    rst = 1'b1;
    waitCycles(4);
    checkOutput("midreset_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("midreset_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    waitCycles(100);
    e = '{data: 8'h66, typ: 1'b0, perr: 1'b0, ferr: 1'b0};
    sb.push_back(e);
    sendFrame(8'h66, 1'b0, ^8'h66, 1'b1, BIT_CLKS);
    driveBit(1'b1, 200);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    checkOutput("delivered_count", 32'(delivered), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
